// File: rtl/srl_rule_updater.sv
`default_nettype none
// ============================================================================
// Module      : srl_rule_updater
// Description : Rule update engine for an SRL-based TCAM. It walks every SRL
//               address and shifts one ternary match bit per key segment into
//               the selected rule column. While idle, it drives the lookup key
//               onto the shared SRL address bus.
// Revision    : 1.0 - initial release
// ============================================================================
module srl_rule_updater #(
    parameter int SEG_W    = 5,
    parameter int NUM_SEG  = 4,
    parameter int NUM_RULE = 8,
    parameter int RID_W    = 3
) (
    input  logic                     wclk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [SEG_W*NUM_SEG-1:0] s_key,
    input  logic [SEG_W*NUM_SEG-1:0] s_mask,
    input  logic [RID_W-1:0]         s_rule_id,
    input  logic                     s_op,
    input  logic [SEG_W*NUM_SEG-1:0] lookup_key,
    output logic [SEG_W*NUM_SEG-1:0] srl_addr,
    output logic [NUM_SEG-1:0]       srl_d,
    output logic [NUM_RULE-1:0]      srl_ce,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int               c_KW      = SEG_W * NUM_SEG;
    localparam logic [SEG_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEG_W-1:0]    r_cnt;
    logic [SEG_W-1:0]    w_cnt_nxt;
    logic [SEG_W-1:0]    w_cnt_dec;
    logic [c_KW-1:0]     r_key;
    logic [c_KW-1:0]     r_mask;
    logic [RID_W-1:0]    r_rid;
    logic                r_op;
    logic                w_accept;
    logic                w_oor;
    logic [NUM_SEG-1:0]  w_d_nxt;
    logic [NUM_RULE-1:0] w_ce_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;

    // Segment i matches address a when every unmasked bit of a equals the key.
    function automatic logic [NUM_SEG-1:0] f_match(
        input logic [SEG_W-1:0] cnt,
        input logic [c_KW-1:0]  key,
        input logic [c_KW-1:0]  mask,
        input logic             op
    );
        logic [NUM_SEG-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            res[i] = ~op & (((cnt ^ key[i*SEG_W +: SEG_W]) & ~mask[i*SEG_W +: SEG_W]) == '0);
        end
        return res;
    endfunction

    // Out-of-range ids decode to no column at all.
    function automatic logic [NUM_RULE-1:0] f_onehot(input logic [RID_W-1:0] rid);
        logic [NUM_RULE-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_RULE; i++) begin
            if (int'(rid) == i) begin
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    assign s_ready   = (r_state == S_IDLE) & ~rst;
    assign busy      = (r_state != S_IDLE);
    assign srl_addr  = (r_state == S_IDLE) ? lookup_key : {NUM_SEG{r_cnt}};
    assign w_accept  = s_valid & s_ready;
    assign w_cnt_dec = r_cnt - SEG_W'(1);
    assign w_oor     = (int'(r_rid) >= NUM_RULE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_d_nxt     = '0;
        w_ce_nxt    = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = c_CNT_MAX;
                    w_d_nxt     = f_match(c_CNT_MAX, s_key, s_mask, s_op);
                    w_ce_nxt    = f_onehot(s_rule_id);
                end
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = w_oor;
                end else begin
                    // d/ce are registered alongside the address they belong to
                    w_cnt_nxt = w_cnt_dec;
                    w_d_nxt   = f_match(w_cnt_dec, r_key, r_mask, r_op);
                    w_ce_nxt  = f_onehot(r_rid);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            srl_d   <= '0;
            srl_ce  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            srl_d   <= w_d_nxt;
            srl_ce  <= w_ce_nxt;
            done    <= w_done_nxt;
            err     <= w_err_nxt;
        end
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            r_key  <= '0;
            r_mask <= '0;
            r_rid  <= '0;
            r_op   <= 1'b0;
        end else if (w_accept) begin
            r_key  <= s_key;
            r_mask <= s_mask;
            r_rid  <= s_rule_id;
            r_op   <= s_op;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_srl_rule_updater.sv
`default_nettype none
// ============================================================================
// Module      : tb_srl_rule_updater
// Description : Directed self-checking bench; one 8-rule and one 6-rule DUT
//               share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srl_rule_updater;

    logic        wclk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [19:0] s_key;
    logic [19:0] s_mask;
    logic [2:0]  s_rule_id;
    logic        s_op;
    logic [19:0] lookup_key;

    logic        ready8, busy8, done8, err8;
    logic [19:0] addr8;
    logic [3:0]  d8;
    logic [7:0]  ce8;
    logic        ready6, busy6, done6, err6;
    logic [19:0] addr6;
    logic [3:0]  d6;
    logic [5:0]  ce6;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc8[$];
    int          acc6[$];
    logic [3:0]  d_log[32];

    srl_rule_updater #(.SEG_W(5), .NUM_SEG(4), .NUM_RULE(8), .RID_W(3)) u_dut8 (
        .wclk(wclk), .rst(rst), .s_valid(s_valid), .s_ready(ready8),
        .s_key(s_key), .s_mask(s_mask), .s_rule_id(s_rule_id), .s_op(s_op),
        .lookup_key(lookup_key), .srl_addr(addr8), .srl_d(d8), .srl_ce(ce8),
        .busy(busy8), .done(done8), .err(err8)
    );

    srl_rule_updater #(.SEG_W(5), .NUM_SEG(4), .NUM_RULE(6), .RID_W(3)) u_dut6 (
        .wclk(wclk), .rst(rst), .s_valid(s_valid), .s_ready(ready6),
        .s_key(s_key), .s_mask(s_mask), .s_rule_id(s_rule_id), .s_op(s_op),
        .lookup_key(lookup_key), .srl_addr(addr6), .srl_d(d6), .srl_ce(ce6),
        .busy(busy6), .done(done6), .err(err6)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) cyc <= cyc + 1;

    // The edge following this negedge is an accept edge.
    always @(negedge wclk) begin
        if (s_valid && ready8) acc8.push_back(cyc);
        if (s_valid && ready6) acc6.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: segment matches address c when c and key agree outside the mask.
    function automatic logic [3:0] m_d(input logic [4:0] c, input logic [19:0] key,
                                       input logic [19:0] mask, input logic op);
        logic [3:0] r;
        logic [4:0] k, m;
        for (int i = 0; i < 4; i++) begin
            k    = key[i*5 +: 5];
            m    = mask[i*5 +: 5];
            r[i] = !op && ((c | m) == (k | m));
        end
        return r;
    endfunction

    function automatic int count_bit(input int b);
        int n = 0;
        for (int k = 0; k < 32; k++) if (d_log[k][b]) n++;
        return n;
    endfunction

    // Entered about 1 ns after a rising edge with both DUTs idle.
    task automatic do_update(input logic [19:0] key, input logic [19:0] mask,
                             input logic [2:0] rid, input logic op,
                             input logic [7:0] ce8_exp, input logic [5:0] ce6_exp,
                             input logic err8_exp, input logic err6_exp);
        logic [4:0] c;
        s_key = key; s_mask = mask; s_rule_id = rid; s_op = op; s_valid = 1'b1;
        chk("ready_before", ready8, 1'b1);
        @(posedge wclk); #1;
        s_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            c = 5'(31 - k);
            d_log[k] = d8;
            chk("shift_ce8", ce8, ce8_exp);
            chk("shift_ce6", ce6, ce6_exp);
            chk("shift_d8", d8, m_d(c, key, mask, op));
            chk("shift_d6", d6, m_d(c, key, mask, op));
            chk("shift_addr", addr8, {4{c}});
            chk("shift_busy", busy8, 1'b1);
            @(posedge wclk); #1;
        end
        chk("done8", done8, 1'b1);
        chk("err8", err8, err8_exp);
        chk("done6", done6, 1'b1);
        chk("err6", err6, err6_exp);
        chk("done_ce8", ce8, 8'h00);
        chk("done_ready", ready8, 1'b0);
        chk("done_busy", busy8, 1'b1);
        @(posedge wclk); #1;
        chk("idle_done", done8, 1'b0);
        chk("idle_ready", ready8, 1'b1);
        chk("idle_busy", busy8, 1'b0);
        chk("idle_addr", addr8, lookup_key);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_key = '0; s_mask = '0; s_rule_id = '0; s_op = 1'b0;
        lookup_key = 20'hABCDE;

        repeat (3) @(posedge wclk);
        #1;
        chk("rst_ce", ce8, 8'h00);
        chk("rst_d", d8, 4'h0);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_err", err8, 1'b0);
        chk("rst_ready", ready8, 1'b0);
        rst = 1'b0;
        @(posedge wclk); #1;
        chk("post_rst_ready", ready8, 1'b1);

        lookup_key = 20'h13579; #1;
        chk("lookup_a", addr8, 20'h13579);
        lookup_key = 20'hABCDE; #1;
        chk("lookup_b", addr8, 20'hABCDE);
        @(posedge wclk); #1;

        // Exact write: segments [3..0] = 2, 8, 26, 5
        do_update(20'h12345, 20'h00000, 3'd3, 1'b0, 8'h08, 6'h08, 1'b0, 1'b0);
        chk("exact_d0_at26", d_log[26][0], 1'b1);
        chk("exact_d0_count", count_bit(0), 1);
        chk("exact_d3_at29", d_log[29][3], 1'b1);
        chk("exact_d3_count", count_bit(3), 1);
        chk("exact_d1_at5", d_log[5][1], 1'b1);

        // Segment 0 fully masked
        do_update(20'h12345, 20'h0001F, 3'd3, 1'b0, 8'h08, 6'h08, 1'b0, 1'b0);
        chk("tern_d0_count", count_bit(0), 32);
        chk("tern_d1_at5", d_log[5][1], 1'b1);
        chk("tern_d1_count", count_bit(1), 1);

        // Only bit 0 of segment 0 masked: addresses 4 and 5 match
        do_update(20'h12345, 20'h00001, 3'd3, 1'b0, 8'h08, 6'h08, 1'b0, 1'b0);
        chk("bit0_d0_cnt4", d_log[27][0], 1'b1);
        chk("bit0_d0_cnt5", d_log[26][0], 1'b1);
        chk("bit0_d0_count", count_bit(0), 2);

        // Delete rule 7 (out of range for the 6-rule DUT)
        do_update(20'h12345, 20'h00000, 3'd7, 1'b1, 8'h80, 6'h00, 1'b0, 1'b1);
        chk("del_d_ones", count_bit(0) + count_bit(1) + count_bit(2) + count_bit(3), 0);

        // Rule 6: valid for 8 rules, out of range for 6
        do_update(20'h00000, 20'h00000, 3'd6, 1'b0, 8'h40, 6'h00, 1'b0, 1'b1);

        // Held s_valid: two accepts one period apart
        acc8.delete(); acc6.delete();
        s_key = 20'h0; s_mask = 20'h0; s_rule_id = 3'd6; s_op = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 100 && acc8.size() < 2; i++) @(posedge wclk);
        #1;
        s_valid = 1'b0;
        chk("hs_accepts8", acc8.size(), 2);
        chk("hs_accepts6", acc6.size(), 2);
        if (acc8.size() >= 2) chk("hs_period8", acc8[1] - acc8[0], 34);
        if (acc6.size() >= 2) chk("hs_period6", acc6[1] - acc6[0], 34);
        for (int i = 0; i < 60 && busy8; i++) begin
            @(posedge wclk); #1;
        end
        chk("hs_idle", busy8, 1'b0);
        @(posedge wclk); #1;

        // Reset during SHIFT cycle 10
        s_key = 20'h12345; s_mask = 20'h0; s_rule_id = 3'd2; s_op = 1'b0; s_valid = 1'b1;
        @(posedge wclk); #1;
        s_valid = 1'b0;
        repeat (10) @(posedge wclk);
        #1;
        chk("mid_ce_before", ce8, 8'h04);
        rst = 1'b1;
        @(posedge wclk); #1;
        chk("mid_rst_ce", ce8, 8'h00);
        chk("mid_rst_busy", busy8, 1'b0);
        chk("mid_rst_done", done8, 1'b0);
        chk("mid_rst_ready", ready8, 1'b0);
        rst = 1'b0;
        @(posedge wclk); #1;
        chk("mid_post_ready", ready8, 1'b1);
        chk("mid_post_done", done8, 1'b0);
        do_update(20'h12345, 20'h00000, 3'd2, 1'b0, 8'h04, 6'h04, 1'b0, 1'b0);
        chk("mid_rewrite_d0", count_bit(0), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
